// File: rtl/iiitb_gc_decoder.sv
// Synchronises an 8-bit Gray count, decodes it to binary and polices the step size.
// Latency SYNC_STAGES+1 edges gray_in -> bin_count; no backpressure (free-running consumer).
module iiitb_gc_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  gray_in,
    output logic [7:0]  bin_count,
    output logic        bin_valid,
    output logic        step_err,
    output logic        wrap,
    output logic [7:0]  err_count,
    output logic [15:0] wrap_count,
    output logic        locked
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

    logic [7:0]             sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic [3:0]             lock_cnt;
    logic [7:0]             g_s;
    logic [7:0]             b;
    logic [7:0]             delta;
    logic [3:0]             lock_nxt;

    assign g_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        b    = '0;
        b[7] = g_s[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g_s[i];
        end
    end

    // bin_count always holds the previous decoded sample, so it doubles as the reference value
    assign delta    = b - bin_count;
    assign lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            vld_pipe   <= '0;
            bin_count  <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            bin_valid <= bin_valid | vld_pipe[SYNC_STAGES-1];
            bin_count <= b;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            // First sample after reset is only a reference: bin_valid is still 0 on that edge
            if (bin_valid) begin
                if (delta == 8'd1) begin
                    lock_cnt <= lock_nxt;
                    if (lock_nxt == LOCK_MAX) begin
                        locked <= 1'b1;
                    end
                    if (bin_count == 8'hFF) begin
                        wrap       <= 1'b1;
                        wrap_count <= wrap_count + 16'd1;
                    end
                end else if (delta != 8'd0) begin
                    step_err <= 1'b1;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iiitb_gc_decoder.sv
// Scoreboard bench for iiitb_gc_decoder: driver predicts each edge's outputs, monitor compares.
module tb_iiitb_gc_decoder;

    localparam int LOCK = 4;

    typedef struct packed {
        logic [7:0]  bin;
        logic        vld;
        logic        serr;
        logic        wrp;
        logic [7:0]  errc;
        logic [15:0] wrapc;
        logic        lck;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gray_in;
    logic [7:0]  bin_count;
    logic        bin_valid;
    logic        step_err;
    logic        wrap;
    logic [7:0]  err_count;
    logic [15:0] wrap_count;
    logic        locked;

    int checks   = 0;
    int failures = 0;

    obs_t exp_q[$];

    // model state
    obs_t       m_exp;
    int         m_run;
    int         m_lockc;
    logic [7:0] gh1, gh2;

    iiitb_gc_decoder #(.SYNC_STAGES(2), .LOCK_COUNT(LOCK)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .bin_count(bin_count),
        .bin_valid(bin_valid), .step_err(step_err), .wrap(wrap), .err_count(err_count),
        .wrap_count(wrap_count), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [7:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] g);
        logic [7:0] r;
        r = g;
        for (int s = 1; s < 8; s++) r = r ^ (g >> s);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one edge's inputs and predict the outputs after that edge.
    task automatic step(input logic r, input logic [7:0] g);
        obs_t       prev;
        logic [7:0] d;
        @(negedge clk);
        reset   = r;
        gray_in = g;
        prev    = m_exp;
        if (r) begin
            m_exp   = '0;
            m_run   = 0;
            m_lockc = 0;
        end else begin
            if (m_run < 3) m_run++;
            m_exp.vld  = (m_run >= 3);
            m_exp.bin  = (m_run >= 3) ? dec(gh2) : 8'h00;
            m_exp.serr = 1'b0;
            m_exp.wrp  = 1'b0;
            if (prev.vld) begin
                d = m_exp.bin - prev.bin;
                if (d == 8'd1) begin
                    if (m_lockc < LOCK) m_lockc++;
                    if (m_lockc == LOCK) m_exp.lck = 1'b1;
                    if (prev.bin == 8'hFF) begin
                        m_exp.wrp   = 1'b1;
                        m_exp.wrapc = prev.wrapc + 16'd1;
                    end
                end else if (d != 8'd0) begin
                    m_exp.serr = 1'b1;
                    m_lockc    = 0;
                    m_exp.lck  = 1'b0;
                    if (prev.errc != 8'hFF) m_exp.errc = prev.errc + 8'd1;
                end
            end
        end
        gh2 = gh1;
        gh1 = g;
        exp_q.push_back(m_exp);
    endtask

    task automatic hold(input logic [7:0] g, input int n);
        for (int i = 0; i < n; i++) step(1'b0, g);
    endtask

    // Monitor: one expected record per clock edge
    initial begin
        obs_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = '{bin: bin_count, vld: bin_valid, serr: step_err, wrp: wrap,
                        errc: err_count, wrapc: wrap_count, lck: locked};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL edge_outputs t=%0t: got bin=%0d vld=%b err=%b wrap=%b errc=%0d wrapc=%0d lck=%b required bin=%0d vld=%b err=%b wrap=%b errc=%0d wrapc=%0d lck=%b",
                             $time, act.bin, act.vld, act.serr, act.wrp, act.errc, act.wrapc, act.lck,
                             e.bin, e.vld, e.serr, e.wrp, e.errc, e.wrapc, e.lck);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        reset   = 1'b1;
        gray_in = 8'h00;
        m_exp   = '0;
        m_run   = 0;
        m_lockc = 0;
        gh1     = '0;
        gh2     = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 8'h00);
        chk("reset_state", {bin_count, bin_valid, step_err, wrap, err_count, wrap_count, locked}, 64'h0);

        // Free count for 300 cycles, passing 255 -> 0 once
        b = 8'd0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, enc(b));
            b++;
            if (i == 2) chk("bin_valid_before_3_edges", bin_valid, 1'b0);
            if (i == 3) chk("bin_valid_at_3_edges", bin_valid, 1'b1);
        end
        chk("count_wrap_count", wrap_count, 16'd1);
        chk("count_err_count", err_count, 8'd0);
        chk("count_locked", locked, 1'b1);

        // Enable 2 on / 3 off
        for (int i = 0; i < 100; i++) begin
            step(1'b0, enc(b));
            if ((i % 5) < 2) b++;
        end
        chk("toggle_err_count", err_count, 8'd0);
        chk("toggle_locked", locked, 1'b1);

        // Advance to 0 cleanly, then jump to binary 2
        while (b != 8'd0) begin
            step(1'b0, enc(b));
            b++;
        end
        hold(8'h00, 4);
        chk("pre_jump_locked", locked, 1'b1);
        hold(8'h03, 4);
        chk("jump_err_count", err_count, 8'd1);
        chk("jump_unlocked", locked, 1'b0);
        for (int v = 3; v <= 6; v++) step(1'b0, enc(8'(v)));
        hold(enc(8'd6), 4);
        chk("relock", locked, 1'b1);

        // 6 -> 3 (jump back) then 3 -> 2 (backward step)
        hold(8'h02, 4);
        hold(8'h03, 4);
        chk("backward_err_count", err_count, 8'd3);

        // Saturate error counter
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 8'h00);
            step(1'b0, 8'h07);
        end
        hold(8'h07, 4);
        chk("err_saturated", err_count, 8'd255);

        // Count to 100, reset mid-count, resume from 0
        for (int v = 0; v <= 100; v++) step(1'b0, enc(8'(v)));
        step(1'b1, enc(8'd100));
        step(1'b1, enc(8'd100));
        chk("mid_reset_outputs", {bin_count, bin_valid, step_err, wrap, err_count, wrap_count, locked}, 64'h0);
        step(1'b1, enc(8'd100));
        for (int v = 0; v < 20; v++) step(1'b0, enc(8'(v)));
        hold(enc(8'd19), 4);
        chk("post_reset_err_count", err_count, 8'd0);
        chk("post_reset_wrap_count", wrap_count, 16'd0);
        chk("post_reset_locked", locked, 1'b1);
        chk("post_reset_bin", bin_count, 8'd19);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iiitb_gc_decoder.md
Name: iiitb_gc_decoder

Overview:
Downstream consumer of the 8-bit Gray counter output. It synchronises the Gray bus, converts it to binary and checks that successive values advance by at most one count. It also counts wrap-arounds and step errors, and asserts a lock flag once the counter is seen advancing cleanly. It sits between the Gray counter and any binary-domain logic, such as a pointer-compare stage or a status register block.

Parameters:
SYNC_STAGES, 2, number of input flop stages on gray_in; legal range 2..4.
LOCK_COUNT, 4, consecutive good +1 steps needed to set locked; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
gray_in  input  8  Gray-coded count from the upstream counter.
bin_count  output  8  binary equivalent of the synchronised Gray value.
bin_valid  output  1  high once bin_count holds a converted sample.
step_err  output  1  one-cycle pulse on an illegal step.
wrap  output  1  one-cycle pulse on a 255 -> 0 step.
err_count  output  8  number of step errors; saturates at 255.
wrap_count  output  16  number of wraps; rolls over modulo 65536.
locked  output  1  high after LOCK_COUNT consecutive +1 steps with no intervening error.

Behaviour:
- Clock and reset: clock is clk; reset is reset, synchronous, active-high. All state updates on the rising edge of clk.
- Reset values: every sync flop, bin_count, the previous-value register, err_count, wrap_count and the lock counter clear to 0; bin_valid, step_err, wrap and locked clear to 0.
- Reset takes priority over all other activity.
- Synchroniser: gray_in passes through SYNC_STAGES flops; the last stage is g_s.
- Conversion:
  - b[7] = g_s[7];
  - b[i] = b[i+1] ^ g_s[i] for i = 6..0;
  - purely combinational from g_s.
- Output register: every cycle not in reset, bin_count <= b and prev <= b.
- Latency: a gray_in value stable before edge N appears on bin_count after edge N+SYNC_STAGES, i.e. SYNC_STAGES+1 edges after it was sampled.
- bin_valid:
  - Goes high at the first edge where a post-reset sample reaches bin_count: SYNC_STAGES+1 edges after reset deasserts.
  - Stays high until the next reset.
- Step check: delta = (b - prev) mod 256, evaluated only when bin_valid is already 1. The first sample after reset is the reference and is never checked.
- delta == 0 (counter disabled):
  - no pulse;
  - lock counter and locked unchanged.
- delta == 1:
  - good step; lock counter increments, saturating at LOCK_COUNT;
  - locked <= 1 when the counter reaches LOCK_COUNT.
  - If prev == 255 and b == 0: wrap pulses for 1 cycle and wrap_count increments.
- Any other delta (including 255, a backward step):
  - step_err pulses for 1 cycle;
  - err_count increments, saturating at 255;
  - lock counter clears and locked <= 0 in the same edge.
- Pulse alignment: step_err and wrap are registered and assert in the same cycle that bin_count shows the offending or wrapping value. They are mutually exclusive.
- Wraps and errors never change bin_count; it always reflects the decoded input.
- Reset mid-operation: all state returns to reset values. The first sample after reset re-establishes the reference, so no error is reported against the pre-reset value.
- No handshake with the counter; gray_in is assumed to change at most once per clk.

Test Plan:
- Reset, then count from gray 0 with enable every cycle for 300 cycles (SYNC_STAGES=2):
  - bin_count equals the upstream binary value delayed 3 cycles;
  - bin_valid rises 3 edges after reset deasserts;
  - locked rises after the 4th good step;
  - wrap pulses exactly once, at 255 -> 0; wrap_count = 1;
  - err_count = 0.
- Toggle enable 2 on / 3 off for 100 cycles:
  - bin_count holds during idle cycles;
  - step_err never asserts;
  - locked stays 1 once set.
- Drive gray 0x00, then gray 0x03 (binary 2) while locked:
  - step_err pulses 1 cycle with bin_count = 2;
  - err_count = 1; locked = 0;
  - 4 further clean steps restore locked = 1.
- Drive gray 0x02 (binary 3), then gray 0x03 (binary 2), a backward step:
  - step_err pulses 1 cycle; err_count increments.
- Inject 300 illegal jumps (alternate gray 0x00 / 0x07):
  - err_count saturates at 255 and holds.
- Assert reset mid-count at binary 100, then resume counting from 0:
  - all outputs are 0 during reset;
  - no step_err on the first post-reset sample;
  - wrap_count = 0 and err_count = 0 after reset.
